// File: rtl/apb_chargen_pkg.sv
// Shared definitions for the APB character-write front-end: register
// offsets, bit positions, APB FSM states and the buffered request type.
package apb_chargen_pkg;

   // Character request widths carried through the write buffer
   localparam int CHAR_W      = 8;
   localparam int CHAR_ADDR_W = 12;

   // Register byte offsets (only paddr[3:2] may be nonzero)
   localparam logic [3:0] CTRL_OFFS    = 4'h0;
   localparam logic [3:0] STATUS_OFFS  = 4'h4;
   localparam logic [3:0] WCOUNT_OFFS  = 4'h8;
   localparam logic [3:0] CHAR_WR_OFFS = 4'hC;

   // CTRL bit indices
   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_FLUSH_BIT = 1;

   // STATUS field positions
   localparam int STATUS_EMPTY_BIT = 0;
   localparam int STATUS_FULL_BIT  = 1;
   localparam int STATUS_LEVEL_LSB = 8;
   localparam int STATUS_LEVEL_W   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } apb_fsm_e;

   typedef struct packed {
      logic [CHAR_ADDR_W-1:0] addr;
      logic [CHAR_W-1:0]      code;
   } char_req_t;

endpackage

// File: rtl/chargen_wr_fifo.sv
// Small synchronous FIFO of character requests. A push while full is only
// taken when a pop happens in the same cycle; flush empties it outright.
module chargen_wr_fifo
   import apb_chargen_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  char_req_t                  wdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level,
   output char_req_t                  rdata
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   char_req_t        mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [LW-1:0]    level_reg;
   logic [LW-1:0]    level_next;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_reg == LW'(DEPTH));
   assign empty   = (level_reg == '0);
   assign level   = level_reg;
   assign rdata   = mem[rd_ptr_reg];
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   // Occupancy follows the net effect of this cycle's push and pop
   always_comb begin
      level_next = level_reg;
      if (do_push && !do_pop) begin
         level_next = level_reg + LW'(1);
      end else if (do_pop && !do_push) begin
         level_next = level_reg - LW'(1);
      end
   end

   // Pointer and level state; flush wins over any concurrent push/pop
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         level_reg <= level_next;
      end
   end

   // Storage array; contents need no reset since level gates visibility
   always_ff @(posedge clk_i) begin
      if (do_push && !flush) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

endmodule

// File: rtl/apb_chargen_wbuf.sv
// APB slave that buffers character writes and drains them, one per cycle,
// onto the chargen character-memory write port while enabled.
module apb_chargen_wbuf
   import apb_chargen_pkg::*;
#(
   parameter int APB_ADDR_WIDTH  = 13,
   parameter int APB_DATA_WIDTH  = 32,
   parameter int CHAR_WIDTH      = CHAR_W,
   parameter int CHAR_ADDR_WIDTH = CHAR_ADDR_W,
   parameter int CHAR_COUNT      = 2400,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic [APB_ADDR_WIDTH-1:0]  apb_paddr_i,
   input  logic [APB_DATA_WIDTH-1:0]  apb_pwdata_i,
   input  logic                       apb_pwrite_i,
   input  logic                       apb_psel_i,
   input  logic                       apb_penable_i,
   output logic [APB_DATA_WIDTH-1:0]  apb_prdata_o,
   output logic                       apb_pready_o,
   output logic                       apb_pslverr_o,
   output logic [CHAR_WIDTH-1:0]      char_o,
   output logic [CHAR_ADDR_WIDTH-1:0] char_addr_o,
   output logic                       char_wen_o
);
   localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [APB_ADDR_WIDTH-1:0] REG_SEL_MASK = APB_ADDR_WIDTH'(4'hC);

   apb_fsm_e                   state_reg, state_next;
   logic                       en_reg;
   logic [31:0]                wcount_reg;
   logic [APB_DATA_WIDTH-1:0]  prdata_reg;
   logic                       pslverr_reg;
   logic                       pready_reg;
   logic [CHAR_WIDTH-1:0]      char_reg;
   logic [CHAR_ADDR_WIDTH-1:0] char_addr_reg;
   logic                       char_wen_reg;

   logic                       access;
   logic                       addr_ok;
   logic [3:0]                 reg_offs;
   logic [CHAR_ADDR_WIDTH-1:0] cell_addr;
   logic                       cell_ok;
   logic                       char_wr_ok;
   logic                       ctrl_wr;
   logic                       ctrl_we;
   logic                       acc_err;
   logic [APB_DATA_WIDTH-1:0]  rd_data;
   logic                       resp_load;
   logic                       unused_wdata;

   logic                       fifo_push, fifo_pop, fifo_flush;
   logic                       fifo_full, fifo_empty;
   logic [LEVEL_W-1:0]         fifo_level;
   char_req_t                  fifo_head, wr_req;

   // Address/data decode of the current bus access
   assign access     = apb_psel_i & apb_penable_i;
   assign addr_ok    = (apb_paddr_i & ~REG_SEL_MASK) == '0;
   assign reg_offs   = {apb_paddr_i[3:2], 2'b00};
   assign cell_addr  = apb_pwdata_i[16 +: CHAR_ADDR_WIDTH];
   assign cell_ok    = int'(cell_addr) < CHAR_COUNT;
   assign char_wr_ok = addr_ok & apb_pwrite_i & (reg_offs == CHAR_WR_OFFS) & cell_ok;
   assign ctrl_wr    = addr_ok & apb_pwrite_i & (reg_offs == CTRL_OFFS);
   assign acc_err    = ~addr_ok
                     | (apb_pwrite_i & ((reg_offs == STATUS_OFFS) | (reg_offs == WCOUNT_OFFS)))
                     | (~apb_pwrite_i & (reg_offs == CHAR_WR_OFFS))
                     | (apb_pwrite_i & (reg_offs == CHAR_WR_OFFS) & ~cell_ok);
   assign unused_wdata = ^apb_pwdata_i;

   assign wr_req.addr = cell_addr;
   assign wr_req.code = apb_pwdata_i[CHAR_WIDTH-1:0];

   // CTRL writes only ever execute from IDLE; kept out of the FSM process so
   // flush/pop do not loop back through the next-state logic.
   assign ctrl_we    = (state_reg == IDLE) & access & ctrl_wr;
   assign fifo_flush = ctrl_we & apb_pwdata_i[CTRL_FLUSH_BIT];
   assign fifo_pop   = en_reg & ~fifo_empty & ~fifo_flush;

   // Read-data mux; anything not a legal read returns 0
   always_comb begin
      rd_data = '0;
      if (addr_ok && !apb_pwrite_i) begin
         case (reg_offs)
            CTRL_OFFS:   rd_data[CTRL_EN_BIT] = en_reg;
            STATUS_OFFS: begin
               rd_data[STATUS_EMPTY_BIT] = fifo_empty;
               rd_data[STATUS_FULL_BIT]  = fifo_full;
               rd_data[STATUS_LEVEL_LSB +: LEVEL_W] = fifo_level;
            end
            WCOUNT_OFFS: rd_data = wcount_reg;
            default:     rd_data = '0;
         endcase
      end
   end

   // APB FSM next state, FIFO push and response capture
   always_comb begin
      state_next = state_reg;
      fifo_push  = 1'b0;
      resp_load  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (access) begin
               if (char_wr_ok && fifo_full && !fifo_pop) begin
                  state_next = WAIT;
               end else begin
                  state_next = RESP;
                  resp_load  = 1'b1;
                  fifo_push  = char_wr_ok;
               end
            end
         end
         WAIT: begin
            if (!access) begin
               state_next = IDLE;
            end else if (!fifo_full || fifo_pop) begin
               state_next = RESP;
               resp_load  = 1'b1;
               fifo_push  = 1'b1;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM state and the one-cycle pready strobe that marks RESP
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_reg  <= IDLE;
         pready_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pready_reg <= (state_next == RESP);
      end
   end

   // Response data/error, held until the next completed access
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         prdata_reg  <= '0;
         pslverr_reg <= 1'b0;
      end else if (resp_load) begin
         prdata_reg  <= acc_err ? '0 : rd_data;
         pslverr_reg <= acc_err;
      end
   end

   // CTRL.EN register; FLUSH is a pulse and is never stored
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         en_reg <= 1'b0;
      end else if (ctrl_we) begin
         en_reg <= apb_pwdata_i[CTRL_EN_BIT];
      end
   end

   // Drain stage: a popped head appears on the chargen port the next cycle
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         char_reg      <= '0;
         char_addr_reg <= '0;
         char_wen_reg  <= 1'b0;
         wcount_reg    <= '0;
      end else begin
         char_wen_reg <= fifo_pop;
         if (fifo_pop) begin
            char_reg      <= fifo_head.code;
            char_addr_reg <= fifo_head.addr;
            wcount_reg    <= wcount_reg + 32'd1;
         end
      end
   end

   chargen_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .push   (fifo_push),
      .pop    (fifo_pop),
      .flush  (fifo_flush),
      .wdata  (wr_req),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .level  (fifo_level),
      .rdata  (fifo_head)
   );

   assign apb_prdata_o  = prdata_reg;
   assign apb_pready_o  = pready_reg;
   assign apb_pslverr_o = pslverr_reg;
   assign char_o        = char_reg;
   assign char_addr_o   = char_addr_reg;
   assign char_wen_o    = char_wen_reg;

endmodule

// File: doc/apb_chargen_wbuf.md
Name: apb_chargen_wbuf

Overview:
- APB slave front-end for the VGA character generator.
- Buffers character-write requests in a parametrised FIFO and drains them to the chargen character-memory write port, one per cycle, while enabled.
- Adds status and commit-count readback, real wait-state back-pressure when the FIFO is full, address range checking, and pslverr for illegal accesses.
- Sits between the APB interconnect and the chargen core's char/addr/wen inputs.

Parameters:
- APB_ADDR_WIDTH, 13: APB address width.
- APB_DATA_WIDTH, 32: APB data width; must be 32.
- CHAR_WIDTH, 8: character code width.
- CHAR_ADDR_WIDTH, 12: character-cell address width.
- CHAR_COUNT, 2400: number of valid cells; cell addresses >= CHAR_COUNT are rejected.
- FIFO_DEPTH, 4: write buffer entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- apb_paddr_i  in  APB_ADDR_WIDTH  byte address; bits [3:2] select the register, all other bits must be 0
- apb_pwdata_i  in  APB_DATA_WIDTH  write data
- apb_pwrite_i  in  1  1 = write
- apb_psel_i  in  1  slave select
- apb_penable_i  in  1  access phase
- apb_prdata_o  out  APB_DATA_WIDTH  read data, registered
- apb_pready_o  out  1  transfer complete, registered
- apb_pslverr_o  out  1  error, valid with pready
- char_o  out  CHAR_WIDTH  character code to chargen
- char_addr_o  out  CHAR_ADDR_WIDTH  cell address to chargen
- char_wen_o  out  1  one-cycle write strobe to chargen

Behaviour:
- Reset: every output is 0; FIFO empty; CTRL = 0; WCOUNT = 0; FSM in IDLE.
- Register map:
  - 0x0 CTRL, RW: [0] EN; [1] FLUSH, write-1 self-clearing, always reads 0.
  - 0x4 STATUS, RO: [0] EMPTY, [1] FULL, [15:8] FIFO level.
  - 0x8 WCOUNT, RO: 32-bit count of char_wen_o pulses; wraps at 2^32.
  - 0xC CHAR_WR, WO: pwdata[CHAR_WIDTH-1:0] = code; pwdata[16+CHAR_ADDR_WIDTH-1:16] = cell address. Reads as 0.
- Errors: pslverr=1, with no side effect and prdata=0, for any of:
  - a write to STATUS or WCOUNT;
  - a read of CHAR_WR;
  - nonzero address bits outside [3:2];
  - a CHAR_WR with cell address >= CHAR_COUNT.
- APB FSM states: IDLE, WAIT, RESP.
  - IDLE: when psel & penable are both 1, decode the access.
    - If it is a valid CHAR_WR and the FIFO is full with no pop this cycle, go to WAIT.
    - Otherwise execute the access (register write, FIFO push, or capture read data), register prdata and pslverr, and go to RESP.
  - WAIT: pready stays 0. Re-check every cycle; when a slot frees (full deasserted, or a pop occurs this cycle), push and go to RESP.
  - RESP: pready=1 for exactly one cycle, then go to IDLE.
    - pready never stays high two consecutive cycles.
    - prdata and pslverr are held until the next RESP.
- Latency: minimum one wait state, i.e. pready in the second access cycle. Back-pressure adds one cycle per full cycle.
- Push while full: accepted in the same cycle as a pop, so the FIFO level is unchanged.
- Drain:
  - When EN=1 and the FIFO is not empty, pop the head. On the next cycle drive char_o and char_addr_o from it with char_wen_o=1; WCOUNT increments by 1.
  - Sustained rate is one entry per cycle.
  - When EN=0, char_wen_o=0 and the FIFO holds its contents.
- Order: entries are delivered in FIFO order, with no reordering or loss.
- FLUSH:
  - The FIFO empties on the cycle after the CTRL write; no pop occurs in the flush cycle.
  - An entry already registered on the chargen outputs still completes its char_wen_o pulse.
  - The same CTRL write also applies its EN value.
- A read of STATUS returns the level sampled in the decode cycle.
- Reset mid-transfer: the pending APB transfer is abandoned (pready 0) and FIFO contents are lost.
- psel dropping while in WAIT (protocol violation): return to IDLE with no push.

Decomposition:
- Package apb_chargen_pkg:
  - register offsets (CTRL_OFFS, STATUS_OFFS, WCOUNT_OFFS, CHAR_WR_OFFS);
  - CTRL bit indices;
  - STATUS field positions;
  - the apb_fsm_e enum (IDLE, WAIT, RESP);
  - packed struct char_req_t {addr, code}.
- Sub-module chargen_wr_fifo: synchronous FIFO of char_req_t.
  - Inputs: push, pop, flush.
  - Outputs: full, empty, level, head data.
  - Push is permitted while full only when pop is also asserted.

Test Plan:
- Reset, then read STATUS -> pready on the 2nd access cycle, prdata=0x00000001 (EMPTY), pslverr=0, char_wen_o stays 0.
- With EN=0, write CHAR_WR with data 0x004B0041 four times, then read STATUS -> prdata=0x00000402 (level 4, FULL). Write EN=1 -> four char_wen_o pulses on consecutive cycles, each with char_addr_o=0x04B and char_o=0x41. WCOUNT then reads 4.
- With EN=0 and the FIFO full, issue a fifth CHAR_WR -> pready stays 0. Set EN=1 via a forced pop (test harness enables drain) -> pready rises 1 cycle after the first pop; the fifth entry is delivered last.
- CHAR_WR with cell address 2400 (data 0x09600041) -> pslverr=1, FIFO level unchanged. Cell address 2399 -> accepted, pslverr=0.
- Write STATUS, read CHAR_WR, and access address 0x10 -> each gives pslverr=1, prdata=0, no state change.
- Fill 3 entries with EN=0, write CTRL=0x3 -> STATUS reads EMPTY, no char_wen_o pulse, CTRL reads 0x1. Then assert reset during a WAIT -> all outputs 0 within the reset cycle.
